// File: rtl/mem_access.sv
// Memory-access stage: AXI4-lite loads/stores and ALU pass-through.
// Produces the writeback packet and stalls execute while a bus op is open.
module mem_access #(
  parameter int ADDR_W = 32,
  parameter logic [2:0] PROT = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       st_data,
  input  logic [31:0]       alu_rd,
  input  logic [4:0]        rd_idx,
  output logic              wb_valid,
  output logic [4:0]        wb_idx,
  output logic [31:0]       wb_data,
  output logic              mem_lock,
  output logic              err,
  output logic              axi_awvalid,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [2:0]        axi_awprot,
  input  logic              axi_awready,
  output logic              axi_wvalid,
  output logic [31:0]       axi_wdata,
  output logic [3:0]        axi_wstrb,
  input  logic              axi_wready,
  input  logic              axi_bvalid,
  input  logic [1:0]        axi_bresp,
  output logic              axi_bready,
  output logic              axi_arvalid,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [2:0]        axi_arprot,
  input  logic              axi_arready,
  input  logic              axi_rvalid,
  input  logic [31:0]       axi_rdata,
  input  logic [1:0]        axi_rresp,
  output logic              axi_rready
);

  typedef enum logic [2:0] {
    IDLE, ST_REQ, ST_RESP, LD_REQ, LD_RESP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t state_q, state_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic bready_q, bready_d, arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic wb_valid_q, wb_valid_d, err_q, err_d;
  logic [4:0]  wb_idx_q, wb_idx_d, rd_q, rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [1:0]  lo_q, lo_d;
  logic [2:0]  f3_q, f3_d;

  logic        is_ld, is_st, mis;
  logic [3:0]  size_mask;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;
  logic [31:0] ld_data;
  logic        r_ok;

  assign mem_lock    = (state_q != IDLE);
  assign in_ready    = ~mem_lock;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awprot  = PROT;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_bready  = bready_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_arprot  = PROT;
  assign axi_rready  = rready_q;
  assign wb_valid    = wb_valid_q;
  assign wb_idx      = wb_idx_q;
  assign wb_data     = wb_data_q;
  assign err         = err_q;

  assign is_ld = (opcode == OP_LOAD);
  assign is_st = (opcode == OP_STORE);
  assign mis = (is_ld || is_st) &&
               ((funct3[1:0] == 2'b01 && addr[0]) ||
                (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00));

  always_comb begin
    unique case (funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  // Lane extraction uses the offset/size latched at accept time.
  always_comb begin
    b_lane = 8'(axi_rdata >> {lo_q, 3'b000});
    h_lane = lo_q[1] ? axi_rdata[31:16] : axi_rdata[15:0];
    case (f3_q)
      3'b000:  ld_data = {{24{b_lane[7]}}, b_lane};
      3'b100:  ld_data = {24'b0, b_lane};
      3'b001:  ld_data = {{16{h_lane[15]}}, h_lane};
      3'b101:  ld_data = {16'b0, h_lane};
      default: ld_data = axi_rdata;
    endcase
    if (axi_rresp != 2'b00) ld_data = '0;
  end

  assign r_ok = !arvalid_q || axi_arready;

  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    wb_valid_d = 1'b0;
    err_d      = 1'b0;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    rd_d       = rd_q;
    lo_d       = lo_q;
    f3_d       = f3_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rd_d = rd_idx;
          lo_d = addr[1:0];
          f3_d = funct3;
          if (mis) begin
            err_d = 1'b1;
          end else if (is_st) begin
            state_d   = ST_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = {addr[ADDR_W-1:2], 2'b00};
            wdata_d   = st_data << {addr[1:0], 3'b000};
            wstrb_d   = size_mask << addr[1:0];
          end else if (is_ld) begin
            state_d   = LD_REQ;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            araddr_d  = {addr[ADDR_W-1:2], 2'b00};
          end else begin
            wb_valid_d = 1'b1;
            wb_idx_d   = rd_idx;
            wb_data_d  = alu_rd;
          end
        end
      end
      ST_REQ: begin
        if (axi_awready) awvalid_d = 1'b0;
        if (axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (axi_bvalid) begin
          bready_d = 1'b0;
          state_d  = IDLE;
          err_d    = (axi_bresp != 2'b00);
        end
      end
      LD_REQ, LD_RESP: begin
        if (axi_arready) arvalid_d = 1'b0;
        if (axi_rvalid && r_ok) begin
          rready_d   = 1'b0;
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_idx_d   = rd_q;
          wb_data_d  = ld_data;
          err_d      = (axi_rresp != 2'b00);
        end else if (!arvalid_d) begin
          state_d = LD_RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      rd_q       <= '0;
      lo_q       <= '0;
      f3_q       <= '0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      rd_q       <= rd_d;
      lo_q       <= lo_d;
      f3_q       <= f3_d;
    end
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage in the is17er core.
- Accepts one registered execute result per transaction: opcode, funct3, effective address, store data, ALU result and destination index.
- Loads and stores are performed over a single AXI4-lite master port with correct byte lanes and load extension. All other ops pass through.
- Produces the writeback packet for the register file, and `mem_lock` back to execute to stall issue while a bus transaction is outstanding.

Parameters:
- ADDR_W, 32, AXI address width; the effective address is truncated to this width.
- PROT, 3'b000, constant value driven on `axi_awprot` and `axi_arprot`.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept; high only in IDLE
- opcode  in  7  RV32I opcode; LOAD=7'b0000011, STORE=7'b0100011
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective address (rs1+imm) from execute
- st_data  in  32  rs2 store data
- alu_rd  in  32  execute result for non-memory ops
- rd_idx  in  5  destination register
- wb_valid  out  1  one-cycle writeback strobe
- wb_idx  out  5  writeback register index
- wb_data  out  32  writeback data
- mem_lock  out  1  high whenever state != IDLE
- err  out  1  one-cycle pulse on misalignment or a non-OKAY response
- axi_aw*  out  awvalid 1, awaddr ADDR_W, awprot 3 — AW channel; `axi_awready` in 1
- axi_w*  out  wvalid 1, wdata 32, wstrb 4 — W channel; `axi_wready` in 1
- axi_bvalid  in  1, axi_bresp  in  2, axi_bready  out  1 — B channel
- axi_ar*  out  arvalid 1, araddr ADDR_W, arprot 3 — AR channel; `axi_arready` in 1
- axi_rvalid  in  1, axi_rdata  in  32, axi_rresp  in  2, axi_rready  out  1 — R channel

Behaviour:
- Reset (async, immediate): state IDLE; all AXI valid/ready outputs 0; addr/data/strb outputs 0; wb_valid 0, wb_idx 0, wb_data 0, err 0.
- Accept: occurs on a rising edge with in_valid && in_ready. All inputs are latched on that edge.
- Alignment:
  - H with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - Misaligned access: no bus transaction; err=1 and wb_valid=0 for one cycle; back to IDLE next edge.
- Non-memory op: wb_valid=1, wb_data=alu_rd, wb_idx=rd_idx on the cycle after accept. Stays in IDLE (1-cycle latency, no stall).
- States: IDLE, ST_REQ, ST_RESP, LD_REQ, LD_RESP.
- STORE (IDLE->ST_REQ):
  - axi_awaddr = {addr[ADDR_W-1:2],2'b00}.
  - axi_wdata = st_data << (8*addr[1:0]).
  - axi_wstrb = (B:4'b0001, H:4'b0011, W:4'b1111) << addr[1:0].
  - awvalid and wvalid rise together. Each drops independently on its own handshake, and either may complete first or both in the same cycle.
  - When both have completed: bready=1, go to ST_RESP.
  - On bvalid&&bready: bready=0 and return to IDLE. err=1 that cycle if bresp!=2'b00.
  - Stores never assert wb_valid.
- LOAD (IDLE->LD_REQ):
  - axi_araddr is word-aligned as for stores.
  - arvalid=1 and rready=1. arvalid drops on arready; rready stays high until the R handshake.
  - R may arrive in the same cycle as, or after, the AR handshake. Both are handled, including AR and R completing together.
  - On rvalid&&rready, on the next cycle: wb_valid=1, wb_idx=rd_idx, and wb_data = lane-extracted data.
  - Byte lane = rdata[8*addr[1:0]+:8]; half lane = rdata[16*addr[1]+:16].
  - B/H are sign-extended and BU/HU zero-extended.
  - rresp!=0: wb_data=0, err=1, wb_valid still 1.
  - Return to IDLE.
- Valid/ready rule: valid outputs never drop before their handshake, and address/data outputs are stable while valid.
- mem_lock = (state!=IDLE), combinational from the state register; in_ready = ~mem_lock.
- Reset during a transaction aborts it. Valids drop asynchronously, and no writeback or err is produced for the aborted op.
- Minimum load latency with a zero-wait slave is 3 cycles from accept to wb_valid. Minimum store latency to IDLE is 3 cycles.

Test Plan:
- ALU pass-through: opcode=7'b0110011, alu_rd=32'hDEADBEEF, rd_idx=5 -> next cycle wb_valid=1, wb_data=32'hDEADBEEF, wb_idx=5, no AXI activity.
- Store byte: addr=32'h1003, st_data=32'h000000AB -> awaddr=32'h1000, wstrb=4'b1000, wdata=32'hAB000000. With awready delayed 2 cycles after wready, exactly one handshake each, bready after both, no wb_valid.
- Load byte signed: addr=32'h2002, rdata=32'h0080FF00 -> wb_data=32'hFFFFFF80. Same data with LBU -> 32'h00000080.
- Load half with AR and R in the same cycle: addr=32'h3002, rdata=32'h8001_1234, LH -> wb_data=32'hFFFF8001; mem_lock high throughout, in_ready low.
- Misaligned LW addr=32'h4001 -> err pulse 1 cycle, no arvalid, wb_valid=0. SLVERR (rresp=2'b10) on aligned LW -> wb_data=0, err=1, wb_valid=1.
- Assert rst while awvalid=1 and awready held low -> awvalid/wvalid drop immediately; after release the next op is accepted from IDLE.
